// File: rtl/imm_ext_pkg.sv
// Shared constants for the pipelined immediate extender.
// Holds the extension-mode encodings, the mode width and the default bus widths.
// Imported by imm_ext_core and imm_ext_pipe.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_PASS  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SEXT  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ZEXT  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_UPPER = 2'b11;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMM_W  = 16;
  localparam int DEF_TAG_W  = 5;

endpackage

// File: rtl/imm_ext_core.sv
// Purpose: combinational immediate extender (pass / sign / zero / upper).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; no handshake at this level.
// Ports: instr (DATA_W) instruction word, mode (MODE_W) selector,
//        result (DATA_W) extended operand. Immediate is instr[IMM_W-1:0].
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W  = DEF_IMM_W
) (
  input  logic [DATA_W-1:0] instr,
  input  logic [MODE_W-1:0] mode,
  output logic [DATA_W-1:0] result
);

  logic [IMM_W-1:0] imm;

  assign imm = instr[IMM_W-1:0];

  // Size casts instead of replication so IMM_W == DATA_W stays legal
  // (a zero-width replication would otherwise appear).
  always_comb begin
    result = instr;
    case (mode)
      MODE_PASS:  result = instr;
      MODE_SEXT:  result = DATA_W'($signed(imm));
      MODE_ZEXT:  result = DATA_W'(imm);
      MODE_UPPER: result = DATA_W'(imm) << (DATA_W - IMM_W);
      default:    result = instr;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Purpose: immediate extender feeding a 2-entry skid buffer between decode and execute.
// Latency: 1 cycle from acceptance to visibility on out_*, no bypass.
// Backpressure: in_ready comes only from registered count (and rst_n), never from out_ready.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_instr/in_mode/in_tag input beat;
//        out_valid/out_ready/out_data/out_tag/out_mode head entry (zeroed when empty).
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [MODE_W-1:0] out_mode
);

  logic [DATA_W-1:0] ext_result;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .instr  (in_instr),
    .mode   (in_mode),
    .result (ext_result)
  );

  // Only the extended value is stored; raw instructions never enter the buffer.
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [TAG_W-1:0]  tag_q  [2];
  logic [TAG_W-1:0]  tag_d  [2];
  logic [MODE_W-1:0] mode_q [2];
  logic [MODE_W-1:0] mode_d [2];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  logic push;
  logic pop;

  assign in_ready  = (count_q != 2'd2) & rst_n;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = out_valid ? data_q[head_q] : '0;
  assign out_tag  = out_valid ? tag_q[head_q]  : '0;
  assign out_mode = out_valid ? mode_q[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < 2; i++) begin
      data_d[i] = data_q[i];
      tag_d[i]  = tag_q[i];
      mode_d[i] = mode_q[i];
    end

    // With count==1 and push&pop together, tail != head, so the new beat
    // lands in the other slot and becomes the head once the pop advances.
    if (push) begin
      data_d[tail_q] = ext_result;
      tag_d[tail_q]  = in_tag;
      mode_d[tail_q] = in_mode;
      tail_d         = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        mode_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
        mode_q[i] <= mode_d[i];
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Purpose: self-checking bench for imm_ext_pipe (default widths and IMM_W=12 variant).
// Latency: inputs driven 1 time unit after posedge; outputs sampled 2 units after posedge.
// Backpressure: exercised via out_ready sequences (fill, stream, mid-buffer reset).
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, v_in_valid;
  logic        in_ready, v_in_ready;
  logic [31:0] in_instr;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid, v_out_valid;
  logic        out_ready;
  logic [31:0] out_data, v_out_data;
  logic [4:0]  out_tag, v_out_tag;
  logic [1:0]  out_mode, v_out_mode;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_mode(out_mode)
  );

  imm_ext_pipe #(.DATA_W(32), .IMM_W(12), .TAG_W(5)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v_in_valid), .in_ready(v_in_ready),
    .in_instr(in_instr), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(v_out_valid), .out_ready(out_ready),
    .out_data(v_out_data), .out_tag(v_out_tag), .out_mode(v_out_mode)
  );

  typedef struct {
    bit          v12;
    logic [1:0]  mode;
    logic [31:0] instr;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge: safe point to drive inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle before sampling outputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    logic [4:0]  got_tags[$];
    logic [31:0] got_data[$];
    bit          pend;
    bit          seen_old;
    logic        rdy, ov;
    logic [31:0] od;
    logic [4:0]  ot;
    logic [1:0]  om;

    // v12, mode, instr, tag, expected
    vecs[0]  = '{1'b0, 2'b00, 32'h89081BA6, 5'd1,  32'h89081BA6};
    vecs[1]  = '{1'b0, 2'b01, 32'hFFFF00AD, 5'd2,  32'h000000AD};
    vecs[2]  = '{1'b0, 2'b01, 32'h0000FD72, 5'd3,  32'hFFFFFD72};
    vecs[3]  = '{1'b0, 2'b10, 32'h0000FD72, 5'd4,  32'h0000FD72};
    vecs[4]  = '{1'b0, 2'b11, 32'h1234ABCD, 5'd5,  32'hABCD0000};
    vecs[5]  = '{1'b0, 2'b10, 32'hFFFF8001, 5'd6,  32'h00008001};
    vecs[6]  = '{1'b0, 2'b01, 32'h12347FFF, 5'd31, 32'h00007FFF};
    vecs[7]  = '{1'b1, 2'b01, 32'h00000800, 5'd7,  32'hFFFFF800};
    vecs[8]  = '{1'b1, 2'b11, 32'h00000ABC, 5'd8,  32'hABC00000};
    vecs[9]  = '{1'b1, 2'b10, 32'hFFFFFFFF, 5'd9,  32'h00000FFF};
    vecs[10] = '{1'b1, 2'b01, 32'hFFFFF7FF, 5'd10, 32'h000007FF};

    // ---- Reset: inputs active, buffer must stay empty and not ready
    rst_n = 1'b0; in_valid = 1'b1; v_in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'hDEADBEEF; in_mode = 2'b00; in_tag = 5'd17;
    for (int c = 0; c < 2; c++) begin
      step();
      settle();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    end
    rst_n = 1'b1; in_valid = 1'b0; v_in_valid = 1'b0;
    settle();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_v12_in_ready", {31'd0, v_in_ready}, 32'd1);

    // ---- Mode table, one beat each with consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      in_instr = vecs[i].instr; in_mode = vecs[i].mode; in_tag = vecs[i].tag;
      in_valid = !vecs[i].v12; v_in_valid = vecs[i].v12;
      settle();
      rdy = vecs[i].v12 ? v_in_ready  : in_ready;
      ov  = vecs[i].v12 ? v_out_valid : out_valid;
      chk($sformatf("v%0d_in_ready", i), {31'd0, rdy}, 32'd1);
      chk($sformatf("v%0d_no_bypass", i), {31'd0, ov}, 32'd0);
      step();
      in_valid = 1'b0; v_in_valid = 1'b0;
      settle();
      ov = vecs[i].v12 ? v_out_valid : out_valid;
      od = vecs[i].v12 ? v_out_data  : out_data;
      ot = vecs[i].v12 ? v_out_tag   : out_tag;
      om = vecs[i].v12 ? v_out_mode  : out_mode;
      chk($sformatf("v%0d_valid", i), {31'd0, ov}, 32'd1);
      chk($sformatf("v%0d_data", i), od, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), {27'd0, ot}, {27'd0, vecs[i].tag});
      chk($sformatf("v%0d_mode", i), {30'd0, om}, {30'd0, vecs[i].mode});
    end
    step();
    settle();
    chk("tbl_drained", {31'd0, out_valid | v_out_valid}, 32'd0);

    // ---- Backpressure: tags 1,2,3 with consumer stalled
    out_ready = 1'b0;
    in_mode = 2'b00;
    for (int t = 1; t <= 3; t++) begin
      in_valid = 1'b1; in_tag = 5'(t); in_instr = 32'hA000_0000 | t;
      settle();
      chk($sformatf("bp_in_ready_t%0d", t), {31'd0, in_ready}, (t < 3) ? 32'd1 : 32'd0);
      if (t < 3) step();
    end
    // tag 3 held for a couple of cycles while full
    for (int c = 0; c < 2; c++) begin
      step();
      settle();
      chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_head_tag", {27'd0, out_tag}, 32'd1);
    end
    out_ready = 1'b1;
    pend = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (out_valid) begin
        got_tags.push_back(out_tag);
        got_data.push_back(out_data);
      end
      if (pend && in_ready) pend = 1'b0;
      step();
      if (!pend) in_valid = 1'b0;
    end
    chk("bp_count", got_tags.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_tags.size()) begin
        chk($sformatf("bp_order_%0d", k), {27'd0, got_tags[k]}, k + 1);
        chk($sformatf("bp_data_%0d", k), got_data[k], 32'hA000_0000 | (k + 1));
      end
    end

    // ---- Streaming push&pop at count==1, SEXT
    out_ready = 1'b0;
    in_mode = 2'b01; in_tag = 5'd0; in_instr = 32'h0000_8000; in_valid = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_instr = 32'h0000_8000 + i; in_tag = 5'(i);
      settle();
      chk($sformatf("st_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("st_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("st_data_%0d", i), out_data, 32'hFFFF_8000 + (i - 1));
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("st_last_data", out_data, 32'hFFFF_800A);
    step();
    settle();
    chk("st_drained", {31'd0, out_valid}, 32'd0);

    // ---- Reset with buffer full
    out_ready = 1'b0; in_mode = 2'b00;
    for (int t = 20; t <= 21; t++) begin
      in_valid = 1'b1; in_tag = 5'(t); in_instr = 32'hB000_0000 | t;
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("mr_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_data", out_data, 32'd0);
    chk("mr_out_tag", {27'd0, out_tag}, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen_old = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      if (out_valid && (out_tag == 5'd20 || out_tag == 5'd21)) seen_old = 1'b1;
      if (out_valid) seen_old = 1'b1;
      step();
    end
    chk("mr_no_old_beats", {31'd0, seen_old}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
